// File: rtl/tron_fb_pkg.sv
// Shared constants and types for the frameRAM write-port arbiter.
package tron_fb_pkg;

    localparam int          FB_WORDS   = 153600;
    localparam int          FB_ADDR_W  = 19;
    localparam int          FB_DATA_W  = 16;
    localparam logic [15:0] CLEAR_WORD = 16'h0808;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_EDGE = 2'd1,
        WIPE      = 2'd2
    } fb_arb_state_t;

    typedef enum logic {
        RR_RED  = 1'b0,
        RR_BLUE = 1'b1
    } rr_ptr_t;

endpackage

// File: rtl/fb_rr_arb2.sv
// Two-way round-robin arbiter: combinational grant, registered priority pointer.
module fb_rr_arb2 (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_en,
    input  logic i_req_r,
    input  logic i_req_b,
    output logic o_gnt_r,
    output logic o_gnt_b
);
    import tron_fb_pkg::*;

    rr_ptr_t r_ptr;

    always_comb begin
        o_gnt_r = 1'b0;
        o_gnt_b = 1'b0;
        if (i_en) begin
            if (i_req_r && i_req_b) begin
                o_gnt_r = (r_ptr == RR_RED);
                o_gnt_b = (r_ptr == RR_BLUE);
            end else begin
                o_gnt_r = i_req_r;
                o_gnt_b = i_req_b;
            end
        end
    end

    // Every grant hands priority to the other side, contested or not.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ptr <= RR_RED;
        end else if (o_gnt_r) begin
            r_ptr <= RR_BLUE;
        end else if (o_gnt_b) begin
            r_ptr <= RR_RED;
        end
    end

endmodule

// File: rtl/fb_write_arbiter.sv
// Owns the frameRAM write port: round-robin red/blue trail writes plus a full-screen wipe.
// Optional macro FB_ARB_CONFLICT_EN adds the addr_conflict collision pulse output.
module fb_write_arbiter #(
    parameter int              ADDR_W     = tron_fb_pkg::FB_ADDR_W,
    parameter int              DATA_W     = tron_fb_pkg::FB_DATA_W,
    parameter int              FB_WORDS   = tron_fb_pkg::FB_WORDS,
    parameter logic [DATA_W-1:0] CLEAR_WORD = DATA_W'(tron_fb_pkg::CLEAR_WORD)
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              frame_clk,
    input  logic              clear_req,
    output logic              clear_busy,
    input  logic              red_req,
    input  logic [ADDR_W-1:0] red_addr,
    input  logic [DATA_W-1:0] red_data,
    output logic              red_gnt,
    input  logic              blue_req,
    input  logic [ADDR_W-1:0] blue_addr,
    input  logic [DATA_W-1:0] blue_data,
    output logic              blue_gnt,
    output logic              fb_we,
    output logic [ADDR_W-1:0] fb_addr,
    output logic [DATA_W-1:0] fb_data
`ifdef FB_ARB_CONFLICT_EN
    ,
    output logic              addr_conflict
`endif
);
    import tron_fb_pkg::*;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_WORDS - 1);

    fb_arb_state_t     r_state;
    fb_arb_state_t     w_state_nxt;
    logic [ADDR_W-1:0] r_cnt;
    logic [ADDR_W-1:0] w_cnt_nxt;

    logic              r_fclk_s1;
    logic              r_fclk_s2;
    logic              r_fclk_d;
    logic              w_fclk_rise;

    logic              w_arb_en;
    logic              w_gnt_r;
    logic              w_gnt_b;

    logic              r_fb_we;
    logic [ADDR_W-1:0] r_fb_addr;
    logic [DATA_W-1:0] r_fb_data;

    // frame_clk is asynchronous to Clk: two-flop synchroniser then rising-edge detect.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_fclk_s1 <= 1'b0;
            r_fclk_s2 <= 1'b0;
            r_fclk_d  <= 1'b0;
        end else begin
            r_fclk_s1 <= frame_clk;
            r_fclk_s2 <= r_fclk_s1;
            r_fclk_d  <= r_fclk_s2;
        end
    end

    assign w_fclk_rise = r_fclk_s2 & ~r_fclk_d;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= WAIT_EDGE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            IDLE: begin
                if (clear_req) begin
                    w_state_nxt = WAIT_EDGE;
                end
            end
            WAIT_EDGE: begin
                if (w_fclk_rise) begin
                    w_state_nxt = WIPE;
                end
            end
            WIPE: begin
                if (r_cnt == LAST_ADDR) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt   = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = WAIT_EDGE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Trail writers only see the port while no wipe is pending or running.
    assign w_arb_en = (r_state == IDLE) && !Reset;

    fb_rr_arb2 u_rr (
        .i_clk   (Clk),
        .i_rst   (Reset),
        .i_en    (w_arb_en),
        .i_req_r (red_req),
        .i_req_b (blue_req),
        .o_gnt_r (w_gnt_r),
        .o_gnt_b (w_gnt_b)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_fb_we   <= 1'b0;
            r_fb_addr <= '0;
            r_fb_data <= '0;
        end else if (r_state == WIPE) begin
            r_fb_we   <= 1'b1;
            r_fb_addr <= r_cnt;
            r_fb_data <= CLEAR_WORD;
        end else if (w_gnt_r) begin
            r_fb_we   <= 1'b1;
            r_fb_addr <= red_addr;
            r_fb_data <= red_data;
        end else if (w_gnt_b) begin
            r_fb_we   <= 1'b1;
            r_fb_addr <= blue_addr;
            r_fb_data <= blue_data;
        end else begin
            r_fb_we   <= 1'b0;
        end
    end

`ifdef FB_ARB_CONFLICT_EN
    logic r_conflict;

    // Head-on hint only; arbitration still serialises both writes.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_conflict <= 1'b0;
        end else begin
            r_conflict <= (r_state == IDLE) && red_req && blue_req && (red_addr == blue_addr);
        end
    end

    assign addr_conflict = r_conflict;
`endif

    assign clear_busy = (r_state != IDLE);
    assign red_gnt    = w_gnt_r;
    assign blue_gnt   = w_gnt_b;
    assign fb_we      = r_fb_we;
    assign fb_addr    = r_fb_addr;
    assign fb_data    = r_fb_data;

endmodule
